inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch control stage wrapped around the PC register. It takes the current PC, issues in-order requests to the instruction memory over an addr_ok/data_ok handshake, and drives the next PC back into the PC register. Returned instructions are buffered in a small FIFO and presented to decode with a valid/ready handshake. Redirects from branch/exception resolution flush the FIFO and discard in-flight responses.

## Interface
- ADDR_WIDTH, 32, PC/address width
- RESET_PC, 32'h0000_0000, next_pc_o value during reset; equals the PC register reset value
- DEPTH, 2, FIFO entries and maximum in-flight requests (power of two, ≥2)

- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- pc_i  in  ADDR_WIDTH  current PC from PC register
- next_pc_o  out  ADDR_WIDTH  next PC to PC register (combinational)
- imem_req  out  1  request valid
- imem_addr  out  ADDR_WIDTH  request address
- imem_addr_ok  in  1  request accepted this cycle
- imem_data_ok  in  1  oldest accepted request returns data this cycle
- imem_rdata  in  32  returned instruction
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  ADDR_WIDTH  restart address
- out_valid  out  1  FIFO head valid
- out_ready  in  1  decode accepts head
- out_pc  out  ADDR_WIDTH  PC of head entry
- out_inst  out  32  instruction of head entry
- out_adel  out  1  head entry is an address-error entry

## Operation
- State: FIFO of DEPTH entries {pc, inst, adel}; inflight counter (accepted, not yet returned); discard counter; halt flag; PC queue of DEPTH entries for in-flight addresses.
- Issue credit: inflight + fifo_count < DEPTH.
- imem_req = !rst && !halt && !redirect_valid-independent && credit && aligned-or-check-off. imem_addr = pc_i.
- next_pc_o priority: rst → RESET_PC; redirect_valid → redirect_pc; imem_req && imem_addr_ok → pc_i + 4 (mod 2^ADDR_WIDTH, wraps); else pc_i.
- On accept: inflight+1, push pc_i into PC queue.
- On data_ok: inflight−1, pop PC queue; if discard > 0 then discard−1 and drop data; else push {popped pc, imem_rdata, 0} into FIFO.
- Redirect: FIFO cleared, halt cleared; discard ← all requests in flight at end of cycle (including one accepted this cycle, excluding one returning this cycle); PC queue entries retained for discard accounting.
- FIFO pop when out_valid && out_ready; push and pop in the same cycle allowed at any occupancy, including full.
- data_ok with inflight == 0 is a protocol error; ignored.

## Timing
- Reset values: out_valid 0, out_pc 0, out_inst 0, out_adel 0, imem_req 0, next_pc_o RESET_PC; all counters 0, halt 0, FIFO empty.
- Reset mid-operation discards everything; responses arriving after reset deassertion for pre-reset requests are the memory's responsibility (memory reset in the same cycle).
- Minimum latency: accept in cycle N, data_ok N+1, out_valid N+2 (no FIFO bypass).
- Sustained throughput one instruction/cycle with data_ok at N+1 and DEPTH ≥ 2.
- Redirect in cycle N: out_valid 0 in N+1; first request to redirect_pc in N+1 (pc_i updated).
- Redirect coincident with data_ok: that data is dropped. Coincident with out handshake: handshake completes, FIFO still cleared.

## Configuration
- FETCH_ADEL_CHECK_EN defined: if pc_i[1:0] != 0, no request issued; when inflight == 0 and FIFO not full, push {pc_i, 32'h0, adel=1}, set halt (imem_req 0, next_pc_o = pc_i) until redirect_valid.
- Not defined: pc_i[1:0] ignored; imem_addr = {pc_i[ADDR_WIDTH-1:2], 2'b00}; out_adel tied 0; no halt flag.

## Test plan
- Reset then release, addr_ok/data_ok always 1 and out_ready 1 → out_pc 0x0, 0x4, 0x8 on consecutive cycles from cycle 2; next_pc_o = 0x0 during rst.
- out_ready 0 for 10 cycles → FIFO holds 2 entries, imem_req drops to 0, next_pc_o holds pc_i; ready 1 → entries drain in order without loss.
- Two requests in flight (0x10, 0x14), redirect to 0x100 → both responses dropped, first out_pc is 0x100, out_inst matches memory at 0x100.
- Redirect in same cycle as data_ok and addr_ok → returning data dropped, accepted request discarded; next_pc_o = redirect_pc.
- With FETCH_ADEL_CHECK_EN, redirect to 0x102 → one entry out_pc 0x102, out_adel 1, out_inst 0; no imem_req until redirect to 0x200 resumes fetch.
- pc_i = 0xFFFF_FFFC accepted → next_pc_o = 0x0000_0000.

Source files
------------

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch control: imem request tracking, fetch FIFO, redirect flush
// Optional misaligned-PC address-error entries are enabled by FETCH_ADEL_CHECK_EN.
module inst_fetch #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] pc_i,
   output logic [ADDR_WIDTH-1:0] next_pc_o,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_addr_ok,
   input  logic                  imem_data_ok,
   input  logic [31:0]           imem_rdata,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic [31:0]           out_inst,
   output logic                  out_adel
);
   localparam int            PW   = $clog2(DEPTH);
   localparam int            CW   = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [ADDR_WIDTH-1:0] fifo_pc_q   [DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_pc_d   [DEPTH];
   logic [31:0]           fifo_inst_q [DEPTH];
   logic [31:0]           fifo_inst_d [DEPTH];
   logic [PW-1:0]         fifo_rd_q, fifo_rd_d;
   logic [PW-1:0]         fifo_wr_q, fifo_wr_d;
   logic [CW-1:0]         fifo_cnt_q, fifo_cnt_d;
   logic [ADDR_WIDTH-1:0] pcq_q [DEPTH];
   logic [ADDR_WIDTH-1:0] pcq_d [DEPTH];
   logic [PW-1:0]         pcq_rd_q, pcq_rd_d;
   logic [PW-1:0]         pcq_wr_q, pcq_wr_d;
   logic [CW-1:0]         inflight_q, inflight_d;
   logic [CW-1:0]         discard_q, discard_d;

   logic                  misaligned, halted, adel_push;
   logic                  pop, accept, resp, fifo_push;
   logic [CW:0]           occupancy;
   logic [ADDR_WIDTH-1:0] push_pc;
   logic [31:0]           push_inst;

   // Credit counts the slot freed by this cycle's pop so a 1-cycle memory streams back-to-back.
   always_comb begin
      pop       = (fifo_cnt_q != '0) && out_ready;
      occupancy = {1'b0, inflight_q} + {1'b0, fifo_cnt_q} - {{CW{1'b0}}, pop};
      imem_req  = !rst && !halted && !misaligned && (occupancy < {1'b0, FULL});
      accept    = imem_req && imem_addr_ok;
      resp      = imem_data_ok && (inflight_q != '0);
      if (rst)
         next_pc_o = RESET_PC;
      else if (redirect_valid)
         next_pc_o = redirect_pc;
      else if (accept)
         next_pc_o = pc_i + ADDR_WIDTH'(4);
      else
         next_pc_o = pc_i;
   end

   always_comb begin
      fifo_pc_d   = fifo_pc_q;
      fifo_inst_d = fifo_inst_q;
      fifo_rd_d   = fifo_rd_q;
      fifo_wr_d   = fifo_wr_q;
      fifo_cnt_d  = fifo_cnt_q;
      pcq_d       = pcq_q;
      pcq_rd_d    = pcq_rd_q;
      pcq_wr_d    = pcq_wr_q;
      inflight_d  = inflight_q + CW'(accept) - CW'(resp);
      discard_d   = discard_q;
      fifo_push   = 1'b0;
      push_pc     = pcq_q[pcq_rd_q];
      push_inst   = imem_rdata;

      if (accept) begin
         pcq_d[pcq_wr_q] = pc_i;
         pcq_wr_d        = pcq_wr_q + 1'b1;
      end
      if (resp) begin
         pcq_rd_d = pcq_rd_q + 1'b1;
         if (discard_q != '0)
            discard_d = discard_q - 1'b1;
         else
            fifo_push = 1'b1;
      end
      if (adel_push) begin
         fifo_push = 1'b1;
         push_pc   = pc_i;
         push_inst = '0;
      end

      // The PC queue keeps stale entries so discarded responses still pop in order.
      if (redirect_valid) begin
         fifo_push  = 1'b0;
         fifo_rd_d  = '0;
         fifo_wr_d  = '0;
         fifo_cnt_d = '0;
         discard_d  = inflight_d;
      end else begin
         if (fifo_push) begin
            fifo_pc_d[fifo_wr_q]   = push_pc;
            fifo_inst_d[fifo_wr_q] = push_inst;
            fifo_wr_d              = fifo_wr_q + 1'b1;
         end
         if (pop)
            fifo_rd_d = fifo_rd_q + 1'b1;
         fifo_cnt_d = fifo_cnt_q + CW'(fifo_push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_rd_q  <= '0;
         fifo_wr_q  <= '0;
         fifo_cnt_q <= '0;
         pcq_rd_q   <= '0;
         pcq_wr_q   <= '0;
         inflight_q <= '0;
         discard_q  <= '0;
      end else begin
         fifo_rd_q  <= fifo_rd_d;
         fifo_wr_q  <= fifo_wr_d;
         fifo_cnt_q <= fifo_cnt_d;
         pcq_rd_q   <= pcq_rd_d;
         pcq_wr_q   <= pcq_wr_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
      end
      fifo_pc_q   <= fifo_pc_d;
      fifo_inst_q <= fifo_inst_d;
      pcq_q       <= pcq_d;
   end

   assign out_valid = (fifo_cnt_q != '0);
   assign out_pc    = out_valid ? fifo_pc_q[fifo_rd_q] : '0;
   assign out_inst  = out_valid ? fifo_inst_q[fifo_rd_q] : '0;

`ifdef FETCH_ADEL_CHECK_EN
   logic halt_q, halt_d;
   logic fifo_adel_q [DEPTH];
   logic fifo_adel_d [DEPTH];

   assign misaligned = (pc_i[1:0] != 2'b00);
   assign halted     = halt_q;
   assign adel_push  = misaligned && !halt_q && (inflight_q == '0) && (fifo_cnt_q != FULL);
   assign imem_addr  = pc_i;
   assign out_adel   = out_valid && fifo_adel_q[fifo_rd_q];

   // Halt until a redirect so the error entry is emitted exactly once.
   always_comb begin
      halt_d      = halt_q;
      fifo_adel_d = fifo_adel_q;
      if (fifo_push)
         fifo_adel_d[fifo_wr_q] = adel_push;
      if (adel_push)
         halt_d = 1'b1;
      if (redirect_valid)
         halt_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst)
         halt_q <= 1'b0;
      else
         halt_q <= halt_d;
      fifo_adel_q <= fifo_adel_d;
   end
`else
   assign misaligned = 1'b0;
   assign halted     = 1'b0;
   assign adel_push  = 1'b0;
   assign imem_addr  = {pc_i[ADDR_WIDTH-1:2], 2'b00};
   assign out_adel   = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch: vector table plus redirect/wrap sequences
// Covers the FETCH_ADEL_CHECK_EN sequence only when that macro is defined.
module tb_inst_fetch;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_i;
   logic [31:0] next_pc_o;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_addr_ok;
   logic        imem_data_ok;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_adel;

   inst_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
      .clk(clk), .rst(rst), .pc_i(pc_i), .next_pc_o(next_pc_o),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_addr_ok(imem_addr_ok),
      .imem_data_ok(imem_data_ok), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_inst(out_inst), .out_adel(out_adel)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adel;
   } exp_t;

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        aok;
      logic        rsp;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic        exp_req;
      logic [31:0] exp_next;
   } vec_t;

   exp_t        exp_q[$];
   logic [31:0] mem_q[$];
   vec_t        vecs[$];
   logic        rsp_en;
   int          checks = 0;
   int          errors = 0;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return 32'hC0DE_0000 ^ {a[31:2], 2'b00};
   endfunction

   function automatic void add(input logic r, input logic rdy, input logic aok, input logic rsp,
                               input logic ev, input logic [31:0] epc, input logic ereq,
                               input logic [31:0] enext);
      vec_t v;
      v.rst = r; v.rdy = rdy; v.aok = aok; v.rsp = rsp;
      v.exp_valid = ev; v.exp_pc = epc; v.exp_req = ereq; v.exp_next = enext;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic settle();
      imem_data_ok = rsp_en && (mem_q.size() > 0);
      imem_rdata   = imem_data_ok ? mem_f(mem_q[0]) : 32'h0;
      #1;
   endtask

   task automatic advance();
      logic        acc, dok;
      logic [31:0] nxt, addr;
      exp_t        e;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got pc %h with no entry expected", out_pc);
         end else begin
            e = exp_q.pop_front();
            chk("sb_pc", out_pc, e.pc);
            chk("sb_inst", out_inst, e.inst);
            chk("sb_adel", 32'(out_adel), 32'(e.adel));
         end
      end
      acc  = imem_req && imem_addr_ok;
      dok  = imem_data_ok;
      nxt  = next_pc_o;
      addr = imem_addr;
      @(posedge clk);
      #1;
      if (rst) begin
         mem_q.delete();
         exp_q.delete();
      end else begin
         if (dok) void'(mem_q.pop_front());
         if (acc) mem_q.push_back(addr);
         if (redirect_valid) exp_q.delete();
         else if (acc) exp_q.push_back('{pc_i, mem_f(pc_i), 1'b0});
      end
      pc_i = nxt;
   endtask

   task automatic cycle();
      settle();
      advance();
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      cycle();
      redirect_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready    = 1'b1;
      imem_addr_ok = 1'b0;
      rsp_en       = 1'b1;
      repeat (8) cycle();
   endtask

   task automatic expect_first(input string name, input logic [31:0] pc);
      bit seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         settle();
         if (out_valid) begin
            seen = 1'b1;
            chk({name, "_pc"}, out_pc, pc);
            chk({name, "_inst"}, out_inst, mem_f(pc));
         end
         advance();
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no out_valid expected pc %h", name, pc);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; pc_i = 32'h0; imem_addr_ok = 1'b1; rsp_en = 1'b1;
      redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
      imem_data_ok = 1'b0; imem_rdata = 32'h0;

      add(1, 0, 1, 1, 0, 32'h0,  0, 32'h0);
      add(0, 1, 1, 1, 0, 32'h0,  1, 32'h4);
      add(0, 1, 1, 1, 0, 32'h0,  1, 32'h8);
      add(0, 1, 1, 1, 1, 32'h0,  1, 32'hC);
      add(0, 1, 1, 1, 1, 32'h4,  1, 32'h10);
      add(0, 1, 1, 1, 1, 32'h8,  1, 32'h14);
      for (int k = 0; k < 10; k++) add(0, 0, 1, 1, 1, 32'hC, 0, 32'h14);
      add(0, 1, 1, 1, 1, 32'hC,  1, 32'h18);
      add(0, 1, 1, 1, 1, 32'h10, 1, 32'h1C);
      add(0, 1, 1, 1, 1, 32'h14, 1, 32'h20);
      add(0, 1, 1, 1, 1, 32'h18, 1, 32'h24);

      cycle();
      foreach (vecs[i]) begin
         rst = vecs[i].rst; out_ready = vecs[i].rdy;
         imem_addr_ok = vecs[i].aok; rsp_en = vecs[i].rsp;
         settle();
         chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
         chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
         chk($sformatf("vec%0d_next", i), next_pc_o, vecs[i].exp_next);
         if (vecs[i].exp_valid || vecs[i].rst) begin
            chk($sformatf("vec%0d_pc", i), out_pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d_inst", i), out_inst, vecs[i].rst ? 32'h0 : mem_f(vecs[i].exp_pc));
            chk($sformatf("vec%0d_adel", i), 32'(out_adel), 32'h0);
         end
         advance();
      end

      drain();
      redirect_to(32'h10);
      imem_addr_ok = 1'b1; rsp_en = 1'b0;
      cycle();
      cycle();
      settle();
      chk("credit_full_req", 32'(imem_req), 32'h0);
      advance();
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      settle();
      chk("redir_next", next_pc_o, 32'h100);
      advance();
      redirect_valid = 1'b0;
      settle();
      chk("redir_flush_valid", 32'(out_valid), 32'h0);
      advance();
      rsp_en = 1'b1;
      expect_first("redir", 32'h100);

      drain();
      redirect_to(32'h40);
      imem_addr_ok = 1'b1;
      repeat (4) cycle();
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      settle();
      chk("coinc_req", 32'(imem_req), 32'h1);
      chk("coinc_valid", 32'(out_valid), 32'h1);
      chk("coinc_next", next_pc_o, 32'h200);
      advance();
      redirect_valid = 1'b0;
      settle();
      chk("coinc_flush_valid", 32'(out_valid), 32'h0);
      advance();
      expect_first("coinc", 32'h200);

      drain();
      redirect_to(32'hFFFF_FFFC);
      imem_addr_ok = 1'b1;
      settle();
      chk("wrap_req", 32'(imem_req), 32'h1);
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      chk("wrap_next", next_pc_o, 32'h0);
      advance();
      expect_first("wrap", 32'hFFFF_FFFC);

`ifdef FETCH_ADEL_CHECK_EN
      drain();
      redirect_to(32'h102);
      exp_q.push_back('{32'h102, 32'h0, 1'b1});
      imem_addr_ok = 1'b1;
      for (int k = 0; k < 6; k++) begin
         settle();
         chk($sformatf("adel_req%0d", k), 32'(imem_req), 32'h0);
         chk($sformatf("adel_next%0d", k), next_pc_o, 32'h102);
         advance();
      end
      chk("adel_consumed", exp_q.size(), 32'h0);
      redirect_to(32'h200);
      expect_first("adel_resume", 32'h200);
`endif

      drain();
      chk("sb_empty", exp_q.size(), 32'h0);
      settle();
      chk("final_valid", 32'(out_valid), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
